// File: rtl/apb_slave_pkg.sv
// Shared types, widths and helpers for the APB3 register-file completer.
package apb_slave_pkg;

    // Default bus widths for the register-file slave.
    localparam int DEF_AW = 8;
    localparam int DEF_DW = 8;

    // Width of the wait-state counter (supports 0..15 wait states).
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } apb_slv_state_e;

    // True when a word address falls outside the implemented memory.
    function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] depth);
        return (addr >= depth);
    endfunction

endpackage

// File: rtl/apb_slave_regfile_mem.sv
// DEPTH x DW flop array: one synchronous write port, one asynchronous read
// port, asynchronously cleared by presetn. Out-of-range reads return zero
// and out-of-range writes are dropped.
module apb_slv_mem
    import apb_slave_pkg::*;
#(
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW,
    parameter int DEPTH = 64
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    logic [DW-1:0] mem_r [DEPTH];
    logic          waddr_ok_s;
    logic          raddr_ok_s;

    assign waddr_ok_s = !addr_err(32'(waddr), DEPTH_U);
    assign raddr_ok_s = !addr_err(32'(raddr), DEPTH_U);

    // Storage array: cleared on reset, written on a qualified write strobe.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (we && waddr_ok_s) begin
            mem_r[waddr[IW-1:0]] <= wdata;
        end
    end

    // Asynchronous read port with zero returned for addresses past the end.
    always_comb begin
        rdata = '0;
        if (raddr_ok_s) begin
            rdata = mem_r[raddr[IW-1:0]];
        end else begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB3 completer backed by a register-file memory. Transfers are captured in
// the setup phase, optionally stretched by WAIT_CYCLES wait states, and
// answered from registered pready/prdata/pslverr.
module apb_slave_regfile
    import apb_slave_pkg::*;
#(
    parameter int AW          = DEF_AW,
    parameter int DW          = DEF_DW,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 0
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          psel,
    input  logic          penable,
    input  logic          pwrite,
    input  logic [AW-1:0] paddr,
    input  logic [DW-1:0] pwdata,
    output logic [DW-1:0] prdata,
    output logic          pready,
    output logic          pslverr
);

    localparam logic [31:0]      DEPTH_U   = 32'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(WAIT_CYCLES);
    localparam logic             ZERO_WAIT = (WAIT_CYCLES == 0);

    apb_slv_state_e   state_r,   state_nxt_s;
    logic [CNT_W-1:0] cnt_r,     cnt_nxt_s;
    logic [AW-1:0]    addr_r,    addr_nxt_s;
    logic             write_r,   write_nxt_s;
    logic [DW-1:0]    wdata_r,   wdata_nxt_s;
    logic             err_r,     err_nxt_s;
    logic [DW-1:0]    prdata_r,  prdata_nxt_s;
    logic             pready_r,  pready_nxt_s;
    logic             pslverr_r, pslverr_nxt_s;

    logic             setup_err_s;
    logic             mem_we_s;
    logic [AW-1:0]    mem_raddr_s;
    logic [DW-1:0]    mem_rdata_s;

    assign prdata  = prdata_r;
    assign pready  = pready_r;
    assign pslverr = pslverr_r;

    assign setup_err_s = addr_err(32'(paddr), DEPTH_U);
    // In IDLE the live setup address feeds the read port so a zero-wait
    // read can register its data on the setup edge; afterwards the latch.
    assign mem_raddr_s = (state_r == IDLE) ? paddr : addr_r;

    apb_slv_mem #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_mem (
        .pclk    (pclk),
        .presetn (presetn),
        .we      (mem_we_s),
        .waddr   (addr_r),
        .wdata   (wdata_r),
        .raddr   (mem_raddr_s),
        .rdata   (mem_rdata_s)
    );

    // Next-state, setup latch, wait counter and response values.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        addr_nxt_s    = addr_r;
        write_nxt_s   = write_r;
        wdata_nxt_s   = wdata_r;
        err_nxt_s     = err_r;
        prdata_nxt_s  = prdata_r;
        pready_nxt_s  = pready_r;
        pslverr_nxt_s = pslverr_r;
        mem_we_s      = 1'b0;

        case (state_r)
            IDLE: begin
                if (psel && !penable) begin
                    addr_nxt_s  = paddr;
                    write_nxt_s = pwrite;
                    wdata_nxt_s = pwdata;
                    err_nxt_s   = setup_err_s;
                    if (ZERO_WAIT) begin
                        state_nxt_s   = RESP;
                        pready_nxt_s  = 1'b1;
                        pslverr_nxt_s = setup_err_s;
                        prdata_nxt_s  = (pwrite || setup_err_s) ? '0 : mem_rdata_s;
                    end else begin
                        cnt_nxt_s   = CNT_LOAD;
                        state_nxt_s = WAIT;
                    end
                end else begin
                    // No setup phase (including a stray penable): stay idle.
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (!psel) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = '0;
                end else if (penable) begin
                    if (cnt_r == CNT_ONE) begin
                        state_nxt_s   = RESP;
                        cnt_nxt_s     = '0;
                        pready_nxt_s  = 1'b1;
                        pslverr_nxt_s = err_r;
                        prdata_nxt_s  = (write_r || err_r) ? '0 : mem_rdata_s;
                    end else begin
                        cnt_nxt_s = cnt_r - CNT_ONE;
                    end
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP: begin
                if (!psel) begin
                    // Abort: drop the response without touching memory.
                    state_nxt_s   = IDLE;
                    pready_nxt_s  = 1'b0;
                    pslverr_nxt_s = 1'b0;
                    prdata_nxt_s  = '0;
                end else if (penable) begin
                    // Completion edge: commit a clean write, clear outputs.
                    mem_we_s      = write_r && !err_r;
                    state_nxt_s   = IDLE;
                    pready_nxt_s  = 1'b0;
                    pslverr_nxt_s = 1'b0;
                    prdata_nxt_s  = '0;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                cnt_nxt_s     = '0;
                pready_nxt_s  = 1'b0;
                pslverr_nxt_s = 1'b0;
                prdata_nxt_s  = '0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Wait counter, setup latch and registered bus outputs.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt_r     <= '0;
            addr_r    <= '0;
            write_r   <= 1'b0;
            wdata_r   <= '0;
            err_r     <= 1'b0;
            prdata_r  <= '0;
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            addr_r    <= addr_nxt_s;
            write_r   <= write_nxt_s;
            wdata_r   <= wdata_nxt_s;
            err_r     <= err_nxt_s;
            prdata_r  <= prdata_nxt_s;
            pready_r  <= pready_nxt_s;
            pslverr_r <= pslverr_nxt_s;
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench for apb_slave_regfile. Three instances share the APB
// bus signals and differ only in WAIT_CYCLES (0, 3, 2); each has its own psel.
module tb_apb_slave_regfile;

    logic        pclk;
    logic        presetn;
    logic [2:0]  psel_v;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [7:0]  pwdata;
    logic [7:0]  prdata_v  [3];
    logic        pready_v  [3];
    logic        pslverr_v [3];

    int n_tests = 0;
    int n_fail  = 0;

    apb_slave_regfile #(.AW(8), .DW(8), .DEPTH(64), .WAIT_CYCLES(0)) u_wc0 (
        .pclk(pclk), .presetn(presetn), .psel(psel_v[0]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata_v[0]), .pready(pready_v[0]), .pslverr(pslverr_v[0])
    );

    apb_slave_regfile #(.AW(8), .DW(8), .DEPTH(64), .WAIT_CYCLES(3)) u_wc3 (
        .pclk(pclk), .presetn(presetn), .psel(psel_v[1]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata_v[1]), .pready(pready_v[1]), .pslverr(pslverr_v[1])
    );

    apb_slave_regfile #(.AW(8), .DW(8), .DEPTH(64), .WAIT_CYCLES(2)) u_wc2 (
        .pclk(pclk), .presetn(presetn), .psel(psel_v[2]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata_v[2]), .pready(pready_v[2]), .pslverr(pslverr_v[2])
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        int         inst;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
        logic       exp_err;
        int         exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One complete APB transfer starting just after a rising edge. The access
    // phase deliberately scrambles paddr/pwdata to prove they are latched.
    task automatic xfer(input int inst, input logic wr, input logic [7:0] a,
                        input logic [7:0] d, output logic [7:0] rd,
                        output logic er, output int lat);
        psel_v       = 3'b000;
        psel_v[inst] = 1'b1;
        penable      = 1'b0;
        pwrite       = wr;
        paddr        = a;
        pwdata       = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        paddr   = ~a;
        pwdata  = ~d;
        lat = 0;
        rd  = 8'h00;
        er  = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (pready_v[inst]) begin
                lat = k;
                rd  = prdata_v[inst];
                er  = pslverr_v[inst];
                break;
            end
            @(posedge pclk); #1;
        end
        if (lat != 0) begin
            @(posedge pclk); #1;
            check("pready_clears_after_completion", int'(pready_v[inst]), 0);
        end
        psel_v  = 3'b000;
        penable = 1'b0;
    endtask

    logic [7:0] rd;
    logic       er;
    int         lat;
    int         seen;

    initial begin
        presetn = 1'b0;
        psel_v  = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 8'h00;
        pwdata  = 8'h00;

        //           inst wr    addr   wdata  exp_rd exp_err lat
        vecs.push_back('{0, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0, 1});
        vecs.push_back('{0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 1});
        vecs.push_back('{1, 1'b1, 8'h3F, 8'h3C, 8'h00, 1'b0, 4});
        vecs.push_back('{1, 1'b0, 8'h3F, 8'h00, 8'h3C, 1'b0, 4});
        vecs.push_back('{0, 1'b1, 8'h40, 8'hFF, 8'h00, 1'b1, 1});
        vecs.push_back('{0, 1'b0, 8'h40, 8'h00, 8'h00, 1'b1, 1});
        vecs.push_back('{0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1});
        vecs.push_back('{0, 1'b1, 8'h80, 8'h12, 8'h00, 1'b1, 1});
        vecs.push_back('{0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1});
        vecs.push_back('{0, 1'b1, 8'h01, 8'h01, 8'h00, 1'b0, 1});
        vecs.push_back('{0, 1'b1, 8'h02, 8'h02, 8'h00, 1'b0, 1});
        vecs.push_back('{0, 1'b1, 8'h03, 8'h03, 8'h00, 1'b0, 1});
        vecs.push_back('{0, 1'b0, 8'h01, 8'h00, 8'h01, 1'b0, 1});
        vecs.push_back('{0, 1'b0, 8'h02, 8'h00, 8'h02, 1'b0, 1});
        vecs.push_back('{0, 1'b0, 8'h03, 8'h00, 8'h03, 1'b0, 1});
        vecs.push_back('{2, 1'b1, 8'h05, 8'h77, 8'h00, 1'b0, 3});
        vecs.push_back('{2, 1'b0, 8'h05, 8'h00, 8'h77, 1'b0, 3});
        vecs.push_back('{1, 1'b0, 8'h40, 8'h00, 8'h00, 1'b1, 4});

        // Reset state.
        repeat (2) @(posedge pclk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset_prdata",  int'(prdata_v[i]),  0);
            check("reset_pready",  int'(pready_v[i]),  0);
            check("reset_pslverr", int'(pslverr_v[i]), 0);
        end
        presetn = 1'b1;
        @(posedge pclk); #1;

        // Table vectors, applied back-to-back with no idle cycles.
        for (int v = 0; v < vecs.size(); v++) begin
            xfer(vecs[v].inst, vecs[v].wr, vecs[v].addr, vecs[v].wdata, rd, er, lat);
            check($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
            check($sformatf("vec%0d_pslverr", v), int'(er), int'(vecs[v].exp_err));
            if (!vecs[v].wr) begin
                check($sformatf("vec%0d_prdata", v), int'(rd), int'(vecs[v].exp_rd));
            end
        end

        // Abort: WAIT_CYCLES=2 write of 0x11 to 0x05, psel dropped in access cycle 2.
        @(posedge pclk); #1;
        psel_v  = 3'b100;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'h05;
        pwdata  = 8'h11;
        @(posedge pclk); #1;
        penable = 1'b1;
        check("abort_acc1_pready", int'(pready_v[2]), 0);
        @(posedge pclk); #1;
        check("abort_acc2_pready", int'(pready_v[2]), 0);
        psel_v  = 3'b000;
        penable = 1'b0;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge pclk); #1;
            if (pready_v[2]) seen++;
        end
        check("abort_pready_never_rises", seen, 0);
        xfer(2, 1'b0, 8'h05, 8'h00, rd, er, lat);
        check("abort_readback_old", int'(rd), 8'h77);

        // Protocol violation: penable without a setup phase is ignored.
        @(posedge pclk); #1;
        psel_v  = 3'b001;
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = 8'h10;
        pwdata  = 8'h5A;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge pclk); #1;
            if (pready_v[0]) seen++;
        end
        check("no_setup_pready_low", seen, 0);
        psel_v  = 3'b000;
        penable = 1'b0;
        @(posedge pclk); #1;
        xfer(0, 1'b0, 8'h10, 8'h00, rd, er, lat);
        check("no_setup_mem_untouched", int'(rd), 8'hA5);

        // Reset in the middle of a zero-wait read response.
        psel_v  = 3'b001;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 8'h10;
        @(posedge pclk); #1;
        penable = 1'b1;
        check("pre_reset_pready", int'(pready_v[0]), 1);
        check("pre_reset_prdata", int'(prdata_v[0]), 8'hA5);
        #1;
        presetn = 1'b0;
        #1;
        check("midreset_pready",  int'(pready_v[0]),  0);
        check("midreset_prdata",  int'(prdata_v[0]),  0);
        check("midreset_pslverr", int'(pslverr_v[0]), 0);
        psel_v  = 3'b000;
        penable = 1'b0;
        @(posedge pclk); #1;
        presetn = 1'b1;
        @(posedge pclk); #1;
        xfer(0, 1'b0, 8'h10, 8'h00, rd, er, lat);
        check("post_reset_read_10", int'(rd), 0);
        xfer(1, 1'b0, 8'h3F, 8'h00, rd, er, lat);
        check("post_reset_read_3f", int'(rd), 0);
        xfer(0, 1'b0, 8'h02, 8'h00, rd, er, lat);
        check("post_reset_read_02", int'(rd), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
